prbs_15_checker: RTL and testbench
==================================

PRBS_15_CHECKER -- requirements
Module: prbs_15_checker

Interface
REQ-001 Parameter PSEUDO_POLY_SEED, 16'hC001, feedback mask shared with the PRBS-15 generator.
REQ-002 Parameter LOCK_COUNT, 32, consecutive matching valid bits required to declare lock.
REQ-003 Parameter WINDOW, 64, valid-bit length of the loss-of-lock observation window.
REQ-004 Parameter UNLOCK_ERRS, 8, errors within one window that force loss of lock.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  qualifies in_bit on the current edge.
REQ-008 in_bit  input  1  received PRBS-15 bit.
REQ-009 clear  input  1  synchronous clear of err_count and bit_count.
REQ-010 locked  output  1  registered; high while in LOCKED state.
REQ-011 err_pulse  output  1  registered one-cycle strobe per errored bit while locked.
REQ-012 err_count  output  16  registered; saturating count of errored bits while locked.
REQ-013 bit_count  output  32  registered; saturating count of valid bits checked while locked.

Function
REQ-014 The block SHALL hold a 16-bit replica R; expected bit = R[0]; advance: S = (R<<1) mod 2^16, R' = S ^ PSEUDO_POLY_SEED if S[15]==PSEUDO_POLY_SEED[15], else R' = S.
REQ-015 This rule SHALL reproduce the generator bitstream exactly (x^15+x^14+1, period 32767, from R=16'h0001).
REQ-016 FSM states SHALL be HUNT and LOCKED only.
REQ-017 Edges with in_valid=0 SHALL change no state, counter or output, except that err_pulse returns to 0.
REQ-018 HUNT, valid match: R SHALL advance and the match counter SHALL increment.
REQ-019 HUNT, valid mismatch: R SHALL hold (one-bit slip) and the match counter SHALL go to 0.
REQ-020 HUNT SHALL move to LOCKED on the edge that samples the LOCK_COUNT-th consecutive match; locked SHALL be high from that edge.
REQ-021 HUNT SHALL not touch err_pulse, err_count or bit_count.
REQ-022 LOCKED: every valid bit SHALL advance R, whether or not it matches.
REQ-023 LOCKED: every valid bit SHALL increment bit_count, saturating at 32'hFFFFFFFF.
REQ-024 LOCKED mismatch: err_pulse SHALL go high for the next cycle and err_count SHALL increment, saturating at 16'hFFFF.
REQ-025 LOCKED SHALL keep a window bit counter (0..WINDOW-1) and a window error counter.
REQ-026 Both window counters SHALL zero after the WINDOW-th valid bit.
REQ-027 When window errors reach UNLOCK_ERRS, the FSM SHALL enter HUNT on that edge, and the match counter and window counters SHALL zero.
REQ-028 On loss of lock, R SHALL be retained, and err_count and bit_count SHALL hold.
REQ-029 clear SHALL zero err_count and bit_count in any state.
REQ-030 clear coincident with a locked valid bit SHALL give bit_count=1, and err_count=1 if that bit errs, else 0.
REQ-031 clear SHALL not affect the FSM, R or the window counters.
REQ-032 Error and loss-of-lock on the same edge SHALL still count the error and pulse err_pulse.

Reset
REQ-033 reset_n low SHALL immediately, without waiting for a clock edge, set R=16'h0001, state=HUNT, and all counters to 0.
REQ-034 reset_n low SHALL immediately set locked=0, err_pulse=0, err_count=0 and bit_count=0.
REQ-035 Reset SHALL take effect in any state, including mid-window in LOCKED.
REQ-036 Operation SHALL resume on the first rising clk edge after reset_n deasserts.

Verification
REQ-037 Generator stream aligned from reset, in_valid=1 -> locked rises on edge 32, err_count=0, bit_count=N-32 after N bits.
REQ-038 Stream starting at sequence offset 1000 -> locked within 2^17 valid bits, then zero errors for 10000 bits.
REQ-039 Locked, single bit flip -> err_pulse high exactly one cycle, err_count=1, locked stays 1.
REQ-040 Locked, 8 flips within one 64-bit window -> locked falls on the 8th errored edge; err_count=8; relock after 32 clean bits.
REQ-041 Locked, 7 flips per window over 10 windows -> locked stays 1, err_count=70.
REQ-042 in_valid toggling 50% -> results identical to REQ-037 counted in valid bits; clear plus error on the same edge -> err_count=1; reset_n low mid-lock -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/prbs_15_checker_if.sv
// Bit-stream and status bundle between a PRBS-15 source and its checker.
interface prbs_15_checker_if;
    logic        in_valid;
    logic        in_bit;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    modport master (
        output in_valid, in_bit, clear,
        input  locked, err_pulse, err_count, bit_count
    );

    modport slave (
        input  in_valid, in_bit, clear,
        output locked, err_pulse, err_count, bit_count
    );
endinterface

// File: rtl/prbs_15_checker.sv
// PRBS-15 checker: hunts for alignment by one-bit slips, then counts bit errors
// while locked and drops lock when a window collects too many errors.
module prbs_15_checker #(
    parameter logic [15:0] PSEUDO_POLY_SEED = 16'hC001,
    parameter int unsigned LOCK_COUNT       = 32,
    parameter int unsigned WINDOW           = 64,
    parameter int unsigned UNLOCK_ERRS      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    prbs_15_checker_if.slave  bus
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned ERR_W   = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q;
    logic [15:0]          r_q;
    logic [MATCH_W-1:0]   match_cnt_q;
    logic [WIN_W-1:0]     win_bits_q;
    logic [ERR_W-1:0]     win_errs_q;
    logic                 locked_q;
    logic                 err_pulse_q;
    logic [15:0]          err_count_q;
    logic [31:0]          bit_count_q;

    logic                 mismatch_c;
    logic [15:0]          r_next_c;
    logic [15:0]          r_shift_c;
    logic [ERR_W-1:0]     win_errs_nxt_c;

    // Replica advance: shift left, fold the mask back in when the new MSB matches it.
    always_comb begin
        r_shift_c = {r_q[14:0], 1'b0};
        r_next_c  = r_shift_c;
        if (r_shift_c[15] == PSEUDO_POLY_SEED[15]) begin
            r_next_c = r_shift_c ^ PSEUDO_POLY_SEED;
        end
    end

    assign mismatch_c     = bus.in_bit ^ r_q[0];
    assign win_errs_nxt_c = win_errs_q + ERR_W'(mismatch_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            r_q         <= 16'h0001;
            match_cnt_q <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.clear) begin
                err_count_q <= '0;
                bit_count_q <= '0;
            end
            if (bus.in_valid) begin
                case (state_q)
                    HUNT: begin
                        // A mismatch holds the replica so the stream slips past it by one bit.
                        if (!mismatch_c) begin
                            r_q <= r_next_c;
                            if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                                state_q     <= LOCKED;
                                locked_q    <= 1'b1;
                                match_cnt_q <= '0;
                                win_bits_q  <= '0;
                                win_errs_q  <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + MATCH_W'(1);
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        r_q <= r_next_c;
                        if (bus.clear) begin
                            bit_count_q <= 32'd1;
                        end else if (bit_count_q != 32'hFFFF_FFFF) begin
                            bit_count_q <= bit_count_q + 32'd1;
                        end
                        if (mismatch_c) begin
                            err_pulse_q <= 1'b1;
                            if (bus.clear) begin
                                err_count_q <= 16'd1;
                            end else if (err_count_q != 16'hFFFF) begin
                                err_count_q <= err_count_q + 16'd1;
                            end
                        end
                        // Loss-of-lock window; counters also restart on each window boundary.
                        if (win_errs_nxt_c == ERR_W'(UNLOCK_ERRS)) begin
                            state_q     <= HUNT;
                            locked_q    <= 1'b0;
                            match_cnt_q <= '0;
                            win_bits_q  <= '0;
                            win_errs_q  <= '0;
                        end else if (win_bits_q == WIN_W'(WINDOW - 1)) begin
                            win_bits_q  <= '0;
                            win_errs_q  <= '0;
                        end else begin
                            win_bits_q  <= win_bits_q + WIN_W'(1);
                            win_errs_q  <= win_errs_nxt_c;
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_15_checker.sv
// Directed bench for prbs_15_checker: vector table over one continuous stream plus
// hand sequences for async reset, gapped valid and offset acquisition.
module tb_prbs_15_checker;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prbs_15_checker_if bus ();

    prbs_15_checker dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] gen_r;

    typedef struct {
        int n;
        int n_flip;
        bit clr;
        bit valid;
        bit e_locked;
        bit e_pulse;
        int e_err;
        int e_bits;
    } vec_t;

    vec_t vecs[$];

    // x^15+x^14+1 source written in shift/feedback form.
    function automatic logic [15:0] gen_next(input logic [15:0] r);
        return {1'b0, r[13] ^ r[14], r[12:0], r[14]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input bit flip, input bit clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.clear    = clr;
        if (v) begin
            bus.in_bit = gen_r[0] ^ flip;
            gen_r      = gen_next(gen_r);
        end else begin
            bus.in_bit = 1'($urandom);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.clear    = 1'b0;
        reset_n      = 1'b0;
        gen_r        = 16'h0001;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_locked", 32'(bus.locked), 32'd0);
        chk("reset_pulse",  32'(bus.err_pulse), 32'd0);
        chk("reset_err",    32'(bus.err_count), 32'd0);
        chk("reset_bits",   bus.bit_count, 32'd0);

        // {n, n_flip, clr, valid, e_locked, e_pulse, e_err, e_bits}
        vecs.push_back('{31, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{100, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 100});
        vecs.push_back('{1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 101});
        vecs.push_back('{1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 102});
        vecs.push_back('{26, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 26});
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back('{64, 7, 1'b0, 1'b1, 1'b1, 1'b0, 7 * k, 26 + 64 * k});
        end
        vecs.push_back('{7, 7, 1'b0, 1'b1, 1'b1, 1'b1, 77, 673});
        vecs.push_back('{1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 78, 674});
        vecs.push_back('{31, 0, 1'b0, 1'b1, 1'b0, 1'b0, 78, 674});
        vecs.push_back('{1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 78, 674});
        vecs.push_back('{10, 0, 1'b0, 1'b1, 1'b1, 1'b0, 78, 684});
        vecs.push_back('{1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1});
        vecs.push_back('{5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1});

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].valid, k < vecs[i].n_flip, vecs[i].clr && (k == 0));
            end
            chk($sformatf("v%0d_locked", i), 32'(bus.locked),    32'(vecs[i].e_locked));
            chk($sformatf("v%0d_pulse", i),  32'(bus.err_pulse), 32'(vecs[i].e_pulse));
            chk($sformatf("v%0d_err", i),    32'(bus.err_count), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_bits", i),   bus.bit_count,      32'(vecs[i].e_bits));
        end

        // Async reset mid-lock with a pulse pending: outputs clear before any edge.
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_pulse", 32'(bus.err_pulse), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_locked", 32'(bus.locked),    32'd0);
        chk("arst_pulse",  32'(bus.err_pulse), 32'd0);
        chk("arst_err",    32'(bus.err_count), 32'd0);
        chk("arst_bits",   bus.bit_count,      32'd0);
        gen_r = 16'h0001;
        @(negedge clk);
        reset_n = 1'b1;

        // 50% valid duty: same behaviour counted in valid bits.
        for (int k = 0; k < 31; k++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("gap_not_yet", 32'(bus.locked), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("gap_locked", 32'(bus.locked), 32'd1);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("gap_bits", bus.bit_count, 32'd40);
        chk("gap_err",  32'(bus.err_count), 32'd0);

        // Acquisition from a stream starting at sequence offset 1000.
        do_reset();
        repeat (1000) gen_r = gen_next(gen_r);
        begin
            int cnt;
            cnt = 0;
            while (!bus.locked && cnt < (1 << 17)) begin
                step(1'b1, 1'b0, 1'b0);
                cnt++;
            end
        end
        chk("ofs_lock", 32'(bus.locked), 32'd1);
        repeat (10000) step(1'b1, 1'b0, 1'b0);
        chk("ofs_locked", 32'(bus.locked),    32'd1);
        chk("ofs_err",    32'(bus.err_count), 32'd0);
        chk("ofs_bits",   bus.bit_count,      32'd10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
